// File: rtl/tt_ctl_sequencer_pkg.sv
// Shared definitions for the TT mux control sequencer: state encodings, default
// phase lengths and ctl pad bit positions.
package tt_ctl_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DIS    = 3'd1,
        ST_RST    = 3'd2,
        ST_REL    = 3'd3,
        ST_INC_H  = 3'd4,
        ST_INC_L  = 3'd5,
        ST_SETTLE = 3'd6,
        ST_BOOT   = 3'd7
    } seq_state_t;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_PULSE_CYC  = 4;
    localparam int DEF_SETTLE_CYC = 8;

    // Bit positions of the control signals within the ctl[5:0] pad group
    localparam int CTL_SEL_RST_N_BIT = 0;
    localparam int CTL_SEL_INC_BIT   = 1;
    localparam int CTL_ENA_BIT       = 2;

    function automatic int timer_width(input int pulse_cyc, input int settle_cyc);
        int m;
        m = (pulse_cyc > settle_cyc) ? pulse_cyc : settle_cyc;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/tt_ctl_phase_timer.sv
// Loadable down-counter with a zero flag; one instance times every sequencer phase.
module tt_ctl_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/tt_ctl_sequencer.sv
// TT mux select sequencer: disable, reset selector, N increment pulses, settle, enable.
// Optional TT_CTL_SEQ_INCR_EN: remember the selected address and only increment forward.
//
//  state  | meaning
//  BOOT   | held in reset, selector reset asserted, not ready
//  IDLE   | waiting for a request
//  DIS    | ctl_ena low, quiet time before touching the selector
//  RST    | ctl_sel_rst_n low
//  REL    | ctl_sel_rst_n released
//  INC_H  | ctl_sel_inc high
//  INC_L  | ctl_sel_inc low
//  SETTLE | quiet time before ctl_ena is applied
module tt_ctl_sequencer
    import tt_ctl_sequencer_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int PULSE_CYC  = DEF_PULSE_CYC,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_ena,
    output logic              busy,
    output logic              done,
    output logic              ctl_sel_rst_n,
    output logic              ctl_sel_inc,
    output logic              ctl_ena
);

    localparam int TMR_W = timer_width(PULSE_CYC, SETTLE_CYC);
    localparam logic [TMR_W-1:0] PULSE_LD  = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pcnt_q;
    logic [ADDR_W-1:0] incs_d;
    logic              ena_q;
    logic              skip_q, skip_d;
    logic              accept;
    logic              seq_end;
    logic              tmr_load, tmr_zero;
    logic [TMR_W-1:0]  tmr_val;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign seq_end   = (state_q == ST_SETTLE) && tmr_zero;

`ifdef TT_CTL_SEQ_INCR_EN
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic              cur_valid_q;

    assign skip_d = cur_valid_q && (req_addr >= cur_addr_q);
    assign incs_d = skip_d ? (req_addr - cur_addr_q) : req_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            cur_addr_q  <= '0;
            cur_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
            end
            if (seq_end) begin
                cur_addr_q  <= addr_q;
                cur_valid_q <= 1'b1;
            end
        end
    end
`else
    assign skip_d = 1'b0;
    assign incs_d = req_addr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:   state_d = ST_IDLE;
            ST_IDLE:   if (req_valid) state_d = ST_DIS;
            ST_DIS: begin
                if (tmr_zero) begin
                    if (!skip_q)              state_d = ST_RST;
                    else if (pcnt_q == '0)    state_d = ST_SETTLE;
                    else                      state_d = ST_INC_H;
                end
            end
            ST_RST:    if (tmr_zero) state_d = ST_REL;
            ST_REL:    if (tmr_zero) state_d = (pcnt_q == '0) ? ST_SETTLE : ST_INC_H;
            ST_INC_H:  if (tmr_zero) state_d = ST_INC_L;
            ST_INC_L:  if (tmr_zero) state_d = (pcnt_q == ADDR_W'(1)) ? ST_SETTLE : ST_INC_H;
            ST_SETTLE: if (tmr_zero) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Every state change starts a new phase, so the timer reloads on each transition.
    always_comb begin
        tmr_load = (state_d != state_q);
        tmr_val  = PULSE_LD;
        if (state_d == ST_DIS || state_d == ST_SETTLE) begin
            tmr_val = SETTLE_LD;
        end
    end

    tt_ctl_phase_timer #(
        .W (TMR_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Remaining increments; decremented at the end of each low phase, so it stops at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
            ena_q  <= 1'b0;
            skip_q <= 1'b0;
        end else if (accept) begin
            pcnt_q <= incs_d;
            ena_q  <= req_ena;
            skip_q <= skip_d;
        end else if (state_q == ST_INC_L && tmr_zero) begin
            pcnt_q <= pcnt_q - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl_sel_rst_n <= 1'b0;
            ctl_sel_inc   <= 1'b0;
            ctl_ena       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            ctl_sel_rst_n <= (state_d != ST_RST);
            ctl_sel_inc   <= (state_d == ST_INC_H);
            busy          <= (state_d != ST_IDLE) && (state_d != ST_BOOT);
            done          <= seq_end;
            if (state_d == ST_DIS) begin
                ctl_ena <= 1'b0;
            end else if (seq_end) begin
                ctl_ena <= ena_q;
            end
        end
    end

endmodule

// File: tb/tb_tt_ctl_sequencer.sv
// Directed bench for tt_ctl_sequencer; also covers TT_CTL_SEQ_INCR_EN when defined.
module tb_tt_ctl_sequencer;

    localparam int ADDR_W = 10;
    localparam int P      = 4;
    localparam int S      = 8;
`ifdef TT_CTL_SEQ_INCR_EN
    localparam bit INCR = 1'b1;
`else
    localparam bit INCR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ena = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              req_ready, busy, done, ctl_sel_rst_n, ctl_sel_inc, ctl_ena;

    int n_checks = 0;
    int n_fail   = 0;

    int   n_rise = 0, hi_run = 0, lo_run = 0, bad_hi = 0, bad_lo = 0, rstn_low = 0;
    logic inc_prev = 1'b0;

    int m_cur   = 0;
    bit m_valid = 1'b0;

    tt_ctl_sequencer #(
        .ADDR_W     (ADDR_W),
        .PULSE_CYC  (P),
        .SETTLE_CYC (S)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_ena       (req_ena),
        .busy          (busy),
        .done          (done),
        .ctl_sel_rst_n (ctl_sel_rst_n),
        .ctl_sel_inc   (ctl_sel_inc),
        .ctl_ena       (ctl_ena)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ctl_sel_inc && !inc_prev) begin
            n_rise++;
            if (n_rise > 1 && lo_run != P) bad_lo++;
            hi_run = 0;
        end
        if (!ctl_sel_inc && inc_prev) begin
            if (hi_run != P) bad_hi++;
            lo_run = 0;
        end
        if (ctl_sel_inc) hi_run++;
        else lo_run++;
        if (!ctl_sel_rst_n) rstn_low++;
        inc_prev = ctl_sel_inc;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit exp_skip(input int a);
        return INCR && m_valid && (a >= m_cur);
    endfunction

    function automatic int exp_lat(input int a);
        if (exp_skip(a)) return 2*S + 2*P*(a - m_cur);
        return 2*S + 2*P + 2*P*a;
    endfunction

    task automatic start_req(input string tag, input int a, input logic e);
        int w;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = ADDR_W'(a);
        req_ena   = e;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq({tag, "_ready"}, req_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input string tag, input int a, input logic e);
        int lat, exp_l, exp_r, exp_n;
        exp_l = exp_lat(a);
        exp_r = exp_skip(a) ? 0 : P;
        exp_n = exp_skip(a) ? a - m_cur : a;
        start_req(tag, a, e);
        req_valid = 1'b0;
        n_rise = 0; bad_hi = 0; bad_lo = 0; rstn_low = 0;
        check_eq({tag, "_busy"}, busy, 1);
        lat = 0;
        while (!done && lat < exp_l + 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_latency"}, lat, exp_l);
        check_eq({tag, "_inc_rises"}, n_rise, exp_n);
        check_eq({tag, "_inc_high_len"}, bad_hi, 0);
        check_eq({tag, "_inc_low_len"}, bad_lo, 0);
        check_eq({tag, "_rstn_low_cyc"}, rstn_low, exp_r);
        check_eq({tag, "_ena_at_done"}, ctl_ena, e);
        check_eq({tag, "_busy_at_done"}, busy, 0);
        check_eq({tag, "_ready_at_done"}, req_ready, 1);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_one_cycle"}, done, 0);
        m_cur   = a;
        m_valid = 1'b1;
    endtask

    initial begin
        int w, lat, exp_l, n_busy_ready;

        // Reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("rst_sel_rst_n", ctl_sel_rst_n, 0);
        check_eq("rst_sel_inc", ctl_sel_inc, 0);
        check_eq("rst_ena", ctl_ena, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rel_ready_before_edge", req_ready, 0);
        @(posedge clk);
        #1;
        check_eq("rel_ready", req_ready, 1);
        check_eq("rel_sel_rst_n", ctl_sel_rst_n, 1);

        run_req("a3", 3, 1'b1);
        run_req("a0", 0, 1'b0);

        // Hold req_valid through the whole sequence; ready must stay low until done
        exp_l = exp_lat(2);
        start_req("hold", 2, 1'b1);
        n_busy_ready = 0;
        lat = 0;
        while (!done && lat < exp_l + 20) begin
            @(negedge clk);
            if (req_ready) n_busy_ready++;
            @(posedge clk);
            #1;
            lat++;
        end
        req_valid = 1'b0;
        check_eq("hold_latency", lat, exp_l);
        check_eq("hold_ready_while_busy", n_busy_ready, 0);
        m_cur   = 2;
        m_valid = 1'b1;
        @(posedge clk);
        #1;
        check_eq("hold_no_second_accept", busy, 0);

        // Reset during an increment high phase
        start_req("midrst", 5, 1'b1);
        req_valid = 1'b0;
        w = 0;
        while (!ctl_sel_inc && w < 400) begin
            @(negedge clk);
            w++;
        end
        check_eq("midrst_inc_seen", ctl_sel_inc, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_sel_inc", ctl_sel_inc, 0);
        check_eq("midrst_sel_rst_n", ctl_sel_rst_n, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_ena", ctl_ena, 0);
        m_valid = 1'b0;
        m_cur   = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_ready_after", req_ready, 1);

        run_req("a1023", 1023, 1'b1);
        run_req("a1", 1, 1'b0);

`ifdef TT_CTL_SEQ_INCR_EN
        run_req("incr5", 5, 1'b1);
        run_req("incr7", 7, 1'b1);
        run_req("incr2", 2, 1'b1);
        run_req("incr_eq", 2, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
